// File: rtl/split_cond_sched_pkg.sv
// Shared types and constants for split_cond_sched.
package split_cond_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    RESULT  = 2'd2
  } state_e;

  localparam int OFFSET_DEF = 5;
  localparam int STATS_W    = 16;

endpackage

// File: rtl/split_cond_rr_arb.sv
// NREQ-way round-robin arbiter: grants the first valid index at/after ptr_i,
// wrapping past NREQ-1. Purely combinational.
module split_cond_rr_arb #(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  // Scan from the farthest candidate back to ptr_i so the nearest valid wins.
  always_comb begin
    int c;
    c     = 0;
    gnt_o = '0;
    idx_o = '0;
    any_o = |valid_i;
    for (int k = NREQ - 1; k >= 0; k--) begin
      c = (int'(ptr_i) + k) % NREQ;
      if (valid_i[c]) begin
        gnt_o = NREQ'(1) << c;
        idx_o = IW'(c);
      end
    end
  end

endmodule

// File: rtl/split_cond_sched.sv
// Shared add-offset / conditional-override datapath for NREQ requesters.
// Round-robin grant in IDLE, one compute cycle, then the result is held
// until the downstream consumer accepts it.
// Optional macro SPLIT_COND_SCHED_STATS_EN adds saturating result counters.
module split_cond_sched
  import split_cond_sched_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int WIDTH  = 8,
  parameter int OFFSET = OFFSET_DEF,
  parameter int IW     = $clog2(NREQ)
) (
  input  logic                  clk_e,
  input  logic                  rst_e,
  input  logic [NREQ-1:0]       req_valid_e,
  output logic [NREQ-1:0]       req_ready_e,
  input  logic [NREQ-1:0]       req_cond_e,
  input  logic [NREQ*WIDTH-1:0] req_val_e,
  input  logic [NREQ*WIDTH-1:0] req_override_e,
  output logic                  out_valid_e,
  input  logic                  out_ready_e,
  output logic [WIDTH-1:0]      out_val_e,
  output logic                  out_status_e,
  output logic [IW-1:0]         out_id_e
`ifdef SPLIT_COND_SCHED_STATS_EN
  ,
  output logic [STATS_W-1:0]    compute_cnt_e,
  output logic [STATS_W-1:0]    override_cnt_e
`else
`endif
);

  state_e state_q, state_d;

  logic [IW-1:0]    rr_q;
  logic [WIDTH-1:0] val_q, ovr_q;
  logic             cond_q;
  logic [IW-1:0]    id_q;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_val_q;
  logic             out_status_q;
  logic [IW-1:0]    out_id_q;

  logic [NREQ-1:0]  gnt;
  logic [IW-1:0]    gidx;
  logic             any_vld;
  logic [WIDTH-1:0] temp_d;

  split_cond_rr_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
    .valid_i (req_valid_e),
    .ptr_i   (rr_q),
    .gnt_o   (gnt),
    .idx_o   (gidx),
    .any_o   (any_vld)
  );

  // Stage-1 sum; carry out of WIDTH bits is dropped.
  assign temp_d = val_q + WIDTH'(OFFSET);

  // Next-state and grant: only IDLE exposes the arbiter grant.
  always_comb begin
    state_d     = state_q;
    req_ready_e = '0;
    case (state_q)
      IDLE: begin
        req_ready_e = gnt;
        if (any_vld) state_d = COMPUTE;
      end
      COMPUTE: state_d = RESULT;
      RESULT:  if (out_ready_e) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, capture and output registers.
  always_ff @(posedge clk_e) begin
    if (rst_e) begin
      state_q      <= IDLE;
      rr_q         <= '0;
      val_q        <= '0;
      ovr_q        <= '0;
      cond_q       <= 1'b0;
      id_q         <= '0;
      out_valid_q  <= 1'b0;
      out_val_q    <= '0;
      out_status_q <= 1'b0;
      out_id_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (any_vld) begin
          val_q  <= req_val_e[gidx*WIDTH +: WIDTH];
          ovr_q  <= req_override_e[gidx*WIDTH +: WIDTH];
          cond_q <= req_cond_e[gidx];
          id_q   <= gidx;
          rr_q   <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + IW'(1);
        end
        COMPUTE: begin
          out_val_q    <= cond_q ? temp_d : ovr_q;
          out_status_q <= cond_q;
          out_id_q     <= id_q;
          out_valid_q  <= 1'b1;
        end
        RESULT: if (out_ready_e) out_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign out_valid_e  = out_valid_q;
  assign out_val_e    = out_val_q;
  assign out_status_e = out_status_q;
  assign out_id_e     = out_id_q;

`ifdef SPLIT_COND_SCHED_STATS_EN
  logic [STATS_W-1:0] comp_cnt_q, ovr_cnt_q;
  logic               out_hs;

  assign out_hs = (state_q == RESULT) && out_ready_e;

  // Saturating counts of delivered results split by status.
  always_ff @(posedge clk_e) begin
    if (rst_e) begin
      comp_cnt_q <= '0;
      ovr_cnt_q  <= '0;
    end else if (out_hs) begin
      if (out_status_q && (comp_cnt_q != '1)) comp_cnt_q <= comp_cnt_q + 1'b1;
      if (!out_status_q && (ovr_cnt_q != '1)) ovr_cnt_q <= ovr_cnt_q + 1'b1;
    end
  end

  assign compute_cnt_e  = comp_cnt_q;
  assign override_cnt_e = ovr_cnt_q;
`else
  // No statistics in this build.
`endif

endmodule

// File: tb/tb_split_cond_sched.sv
// Self-checking bench for split_cond_sched: directed scenarios plus random
// traffic against a transaction-level reference model.
module tb_split_cond_sched;

  localparam int NREQ   = 2;
  localparam int WIDTH  = 8;
  localparam int OFFSET = 5;
  localparam int IW     = 1;

  logic                  clk_e = 1'b0;
  logic                  rst_e;
  logic [NREQ-1:0]       req_valid_e;
  logic [NREQ-1:0]       req_ready_e;
  logic [NREQ-1:0]       req_cond_e;
  logic [NREQ*WIDTH-1:0] req_val_e;
  logic [NREQ*WIDTH-1:0] req_override_e;
  logic                  out_valid_e;
  logic                  out_ready_e;
  logic [WIDTH-1:0]      out_val_e;
  logic                  out_status_e;
  logic [IW-1:0]         out_id_e;
`ifdef SPLIT_COND_SCHED_STATS_EN
  logic [15:0]           compute_cnt_e;
  logic [15:0]           override_cnt_e;
`endif

  split_cond_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .OFFSET(OFFSET)) dut (
    .clk_e          (clk_e),
    .rst_e          (rst_e),
    .req_valid_e    (req_valid_e),
    .req_ready_e    (req_ready_e),
    .req_cond_e     (req_cond_e),
    .req_val_e      (req_val_e),
    .req_override_e (req_override_e),
    .out_valid_e    (out_valid_e),
    .out_ready_e    (out_ready_e),
    .out_val_e      (out_val_e),
    .out_status_e   (out_status_e),
    .out_id_e       (out_id_e)
`ifdef SPLIT_COND_SCHED_STATS_EN
    ,
    .compute_cnt_e  (compute_cnt_e),
    .override_cnt_e (override_cnt_e)
`endif
  );

  always #5 clk_e = ~clk_e;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: one transaction in flight at most.
  int         rr = 0;
  bit         busy = 0;
  int         age = 0;       // edges since acceptance
  logic [7:0] e_val;
  bit         e_st;
  int         e_id;
  int         ncomp = 0, novr = 0;
  int         last_id = -1;
  int         last_acc_t = 0, cyc = 0;

  // One cycle: drive at negedge, check, predict the coming edge.
  task automatic step(input logic [1:0] v, input logic [1:0] c,
                      input logic [15:0] vals, input logic [15:0] ovrs,
                      input logic ordy);
    int w;
    @(negedge clk_e);
    req_valid_e    = v;
    req_cond_e     = c;
    req_val_e      = vals;
    req_override_e = ovrs;
    out_ready_e    = ordy;
    #1;
    if (!busy) begin
      w = -1;
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && v[(rr + k) % NREQ]) w = (rr + k) % NREQ;
      chk("req_ready", 32'(req_ready_e), (w < 0) ? 0 : (1 << w));
      chk("out_valid_idle", 32'(out_valid_e), 0);
      if (w >= 0) begin
        busy  = 1;
        age   = 0;
        rr    = (w + 1) % NREQ;
        e_st  = c[w];
        e_id  = w;
        e_val = c[w] ? 8'(vals[w*8 +: 8] + OFFSET) : ovrs[w*8 +: 8];
      end
    end else begin
      chk("req_ready_busy", 32'(req_ready_e), 0);
      chk("out_valid", 32'(out_valid_e), 32'(age >= 2));
      if (age >= 2) begin
        chk("out_val", 32'(out_val_e), 32'(e_val));
        chk("out_status", 32'(out_status_e), 32'(e_st));
        chk("out_id", 32'(out_id_e), e_id);
        if (ordy) begin
          busy = 0;
          if (e_st) ncomp++; else novr++;
          last_id = e_id;
        end
      end
    end
    @(posedge clk_e);
    cyc++;
    if (busy) age++;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 2'b00, 16'h0, 16'h0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk_e);
    rst_e = 1'b1;
    req_valid_e = '0;
    out_ready_e = 1'b0;
    @(posedge clk_e);
    #1;
    busy = 0; rr = 0; ncomp = 0; novr = 0;
    chk("rst_out_valid", 32'(out_valid_e), 0);
    chk("rst_out_val", 32'(out_val_e), 0);
    chk("rst_out_status", 32'(out_status_e), 0);
    chk("rst_out_id", 32'(out_id_e), 0);
    @(negedge clk_e);
    rst_e = 1'b0;
  endtask

  initial begin
    int prev_id;
    int alternations;
    rst_e = 1'b1;
    req_valid_e = '0; req_cond_e = '0; req_val_e = '0; req_override_e = '0;
    out_ready_e = 1'b0;
    repeat (2) @(posedge clk_e);
    do_reset();
    chk("rst_req_ready", 32'(req_ready_e), 0);

    // Single req0, cond=1: 0x10 + 5 = 0x15.
    step(2'b01, 2'b01, 16'h0010, 16'h0000, 1'b1);
    idle_steps(4);

    // req1 override, then computed with wrap 0xFE + 5 = 0x03.
    step(2'b10, 2'b00, 16'hFE00, 16'hAA00, 1'b1);
    idle_steps(4);
    step(2'b10, 2'b10, 16'hFE00, 16'hAA00, 1'b1);
    idle_steps(4);
    chk("wrap_last_id", last_id, 1);

    // Both valid continuously: ids must alternate.
    prev_id = -1; alternations = 0;
    for (int i = 0; i < 15; i++) begin
      step(2'b11, 2'b11, 16'h3070, 16'h1122, 1'b1);
      if (last_id >= 0 && prev_id >= 0 && last_id != prev_id) alternations++;
      if (last_id >= 0) prev_id = last_id;
    end
    idle_steps(4);
    chk("alternation_seen", 32'(alternations >= 3), 1);

    // Backpressure: out_ready low for several RESULT cycles, others waiting.
    step(2'b01, 2'b00, 16'h0001, 16'h5A5A, 1'b0);
    for (int i = 0; i < 7; i++) step(2'b11, 2'b11, 16'h2233, 16'h4455, 1'b0);
    step(2'b11, 2'b11, 16'h2233, 16'h4455, 1'b1);
    step(2'b11, 2'b11, 16'h2233, 16'h4455, 1'b1);
    idle_steps(5);

    // Reset during COMPUTE drops the transaction; pointer returns to req0.
    step(2'b01, 2'b01, 16'h0040, 16'h0000, 1'b1);
    do_reset();
    step(2'b11, 2'b01, 16'h0909, 16'h0808, 1'b1);
    idle_steps(4);
    chk("post_rst_grant_id", last_id, 0);

`ifdef SPLIT_COND_SCHED_STATS_EN
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(2'b01, (i < 3) ? 2'b01 : 2'b00, 16'h0011, 16'h0022, 1'b1);
      idle_steps(3);
    end
    chk("compute_cnt", 32'(compute_cnt_e), 3);
    chk("override_cnt", 32'(override_cnt_e), 2);
`endif

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(2'($urandom), 2'($urandom), 16'($urandom), 16'($urandom),
           1'($urandom_range(0, 3) != 0));
    idle_steps(5);

`ifdef SPLIT_COND_SCHED_STATS_EN
    chk("rand_compute_cnt", 32'(compute_cnt_e), ncomp);
    chk("rand_override_cnt", 32'(override_cnt_e), novr);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
